// File: rtl/udp_tx_framer.sv
// rtl/udp_tx_framer.sv - UDP transmit framer: latches header, requests IPv4 TX, emits UDP header then payload.
// Optional length check enabled by defining UDP_TX_LEN_CHECK_EN.
module udp_tx_framer #(
  parameter logic [7:0]  IP_PROTO_UDP = 8'h11,
  parameter logic [15:0] MAX_LEN      = 16'd1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        udp_tx_start,
  input  logic [31:0] udp_hdr_dst_ip,
  input  logic [15:0] udp_hdr_src_port,
  input  logic [15:0] udp_hdr_dst_port,
  input  logic [15:0] udp_hdr_data_length,
  input  logic [15:0] udp_hdr_checksum,
  input  logic [7:0]  udp_data_in,
  input  logic        udp_data_in_valid,
  input  logic        udp_data_in_last,
  output logic        udp_tx_data_out_ready,
  output logic [1:0]  udp_tx_result,
  output logic        ip_tx_start,
  output logic [7:0]  ip_hdr_protocol,
  output logic [15:0] ip_hdr_data_length,
  output logic [31:0] ip_hdr_dst_ip,
  output logic [7:0]  ip_data_out,
  output logic        ip_data_out_valid,
  output logic        ip_data_out_last,
  input  logic [1:0]  ip_tx_result,
  input  logic        ip_tx_data_out_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HDR, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_dst_ip;
  logic [15:0] r_src_port;
  logic [15:0] r_dst_port;
  logic [15:0] r_data_len;
  logic [15:0] r_udp_len;
  logic [15:0] r_cksum;
  logic [2:0]  r_hdr_idx;
  logic [15:0] r_byte_cnt;

  logic        w_ip_err;
  logic        w_len_bad;
  logic        w_active;
  logic        w_hdr_xfer;
  logic        w_data_xfer;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_hdr_byte;

  assign w_ip_err    = (ip_tx_result == 2'b11);
  assign w_len_bad   = (udp_hdr_data_length == 16'd0) || (udp_hdr_data_length > MAX_LEN);
  assign w_active    = (r_state == S_START) || (r_state == S_HDR) ||
                       (r_state == S_DATA)  || (r_state == S_DONE);
  assign w_hdr_xfer  = (r_state == S_HDR) && !w_ip_err && ip_tx_data_out_ready;
  assign w_data_xfer = (r_state == S_DATA) && !w_ip_err && udp_data_in_valid && ip_tx_data_out_ready;
  assign w_cnt_next  = r_byte_cnt + 16'd1;

  assign ip_hdr_protocol    = w_active ? IP_PROTO_UDP : 8'h00;
  assign ip_hdr_data_length = w_active ? r_udp_len : 16'h0000;
  assign ip_hdr_dst_ip      = w_active ? r_dst_ip : 32'h0000_0000;

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_hdr_idx)
      3'd0: w_hdr_byte = r_src_port[15:8];
      3'd1: w_hdr_byte = r_src_port[7:0];
      3'd2: w_hdr_byte = r_dst_port[15:8];
      3'd3: w_hdr_byte = r_dst_port[7:0];
      3'd4: w_hdr_byte = r_udp_len[15:8];
      3'd5: w_hdr_byte = r_udp_len[7:0];
      3'd6: w_hdr_byte = r_cksum[15:8];
      default: w_hdr_byte = r_cksum[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dst_ip   <= '0;
      r_src_port <= '0;
      r_dst_port <= '0;
      r_data_len <= '0;
      r_udp_len  <= '0;
      r_cksum    <= '0;
      r_hdr_idx  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_hdr_idx  <= '0;
          r_byte_cnt <= '0;
          if (udp_tx_start) begin
            r_dst_ip   <= udp_hdr_dst_ip;
            r_src_port <= udp_hdr_src_port;
            r_dst_port <= udp_hdr_dst_port;
            r_data_len <= udp_hdr_data_length;
            r_udp_len  <= udp_hdr_data_length + 16'd8;
            r_cksum    <= udp_hdr_checksum;
          end
        end
        S_HDR:   if (w_hdr_xfer) r_hdr_idx <= r_hdr_idx + 3'd1;
        S_DATA:  if (w_data_xfer) r_byte_cnt <= w_cnt_next;
        default: ;
      endcase
    end
  end

  // An IP-layer error in any active state suppresses all handshakes this cycle.
  always_comb begin
    w_next                = r_state;
    ip_tx_start           = 1'b0;
    udp_tx_data_out_ready = 1'b0;
    ip_data_out           = 8'h00;
    ip_data_out_valid     = 1'b0;
    ip_data_out_last      = 1'b0;
    udp_tx_result         = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (udp_tx_start) w_next = w_len_bad ? S_ERR : S_START;
      end
      S_START: begin
        udp_tx_result = 2'b01;
        if (w_ip_err) begin
          w_next = S_ERR;
        end else begin
          ip_tx_start = 1'b1;
          w_next      = S_HDR;
        end
      end
      S_HDR: begin
        udp_tx_result = 2'b01;
        if (w_ip_err) begin
          w_next = S_ERR;
        end else begin
          ip_data_out       = w_hdr_byte;
          ip_data_out_valid = 1'b1;
          if (w_hdr_xfer && r_hdr_idx == 3'd7) w_next = S_DATA;
        end
      end
      S_DATA: begin
        udp_tx_result = 2'b01;
        if (w_ip_err) begin
          w_next = S_ERR;
        end else begin
          udp_tx_data_out_ready = ip_tx_data_out_ready;
          ip_data_out           = udp_data_in;
          ip_data_out_valid     = udp_data_in_valid;
`ifdef UDP_TX_LEN_CHECK_EN
          ip_data_out_last = udp_data_in_last || (w_cnt_next == r_data_len);
          if (w_data_xfer) begin
            if (udp_data_in_last)
              w_next = (w_cnt_next == r_data_len) ? S_DONE : S_ERR;
            else if (w_cnt_next == r_data_len)
              w_next = S_ERR;
          end
`else
          ip_data_out_last = udp_data_in_last;
          if (w_data_xfer && udp_data_in_last) w_next = S_DONE;
`endif
        end
      end
      S_DONE: begin
        udp_tx_result = 2'b10;
        w_next        = w_ip_err ? S_ERR : S_IDLE;
      end
      S_ERR: begin
        udp_tx_result = 2'b11;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
